// File: rtl/serialising_pe_if.sv
// Stream bundle for serialising_pe: a vector-wide input handshake and an
// element-wide output handshake, plus the output side-band flags.
interface serialising_pe_if #(
   parameter int BitSize   = 2,
   parameter int ImageSize = 9
);
   localparam int IW = $clog2(ImageSize + 1);

   logic                               in_valid;
   logic                               in_ready;
   logic [ImageSize-1:0][BitSize-1:0]  in_data;
   logic                               out_valid;
   logic                               out_ready;
   logic [BitSize-1:0]                 out_data;
   logic [IW-1:0]                      out_index;
   logic                               out_last;
   logic                               out_done;

   // Environment side: offers vectors, consumes elements.
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_index, out_last, out_done
   );

   // Converter side: accepts vectors, produces elements.
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_index, out_last, out_done
   );
endinterface

// File: rtl/serialising_pe.sv
// Parallel-to-serial converter: captures a whole ImageSize-element vector in
// one handshake and replays it one element per beat, highest index first.
module serialising_pe #(
   parameter int BitSize   = 2,
   parameter int ImageSize = 9,
   parameter int Delay     = 0
) (
   input logic           clk,
   input logic           res,
   serialising_pe_if.slave bus
);
   localparam int IW = $clog2(ImageSize + 1);
   // A zero-width counter is not legal, so keep one bit when Delay==0.
   localparam int DW = (Delay > 0) ? $clog2(Delay + 1) : 1;
   localparam logic [IW-1:0] IDX_TOP = IW'(ImageSize - 1);
   // WAIT counts down from Delay-1 to 0, giving exactly Delay idle cycles.
   localparam logic [DW-1:0] DLY_TOP = DW'((Delay > 0) ? Delay - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND} state_t;

   state_t                            state_q, state_d;
   logic [ImageSize-1:0][BitSize-1:0] vec_q, vec_d;
   logic [IW-1:0]                     idx_q, idx_d;
   logic [DW-1:0]                     dly_q, dly_d;
   logic                              done_q, done_d;

   logic                              in_ready_c;
   logic                              out_valid_c;
   logic [BitSize-1:0]                out_data_c;
   logic [IW-1:0]                     out_index_c;
   logic                              out_last_c;

   // State register; reset aborts any vector in flight without a done pulse.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q <= S_IDLE;
         vec_q   <= '0;
         idx_q   <= '0;
         dly_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         idx_q   <= idx_d;
         dly_q   <= dly_d;
         done_q  <= done_d;
      end
   end

   // Next-state and output decode; a vector accept can also happen on the
   // final beat of SEND when Delay==0, giving gap-free back-to-back vectors.
   always_comb begin
      state_d     = state_q;
      vec_d       = vec_q;
      idx_d       = idx_q;
      dly_d       = dly_q;
      done_d      = 1'b0;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      out_data_c  = '0;
      out_index_c = '0;
      out_last_c  = 1'b0;

      case (state_q)
         S_IDLE: begin
            in_ready_c = 1'b1;
         end
         S_WAIT: begin
            if (dly_q == '0) begin
               state_d = S_SEND;
            end else begin
               dly_d = dly_q - DW'(1);
            end
         end
         S_SEND: begin
            out_valid_c = 1'b1;
            out_index_c = idx_q;
            out_last_c  = (idx_q == '0);
            for (int k = 0; k < ImageSize; k++) begin
               if (idx_q == IW'(k)) begin
                  out_data_c = vec_q[k];
               end
            end
            if (bus.out_ready) begin
               if (idx_q == '0) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
                  if (Delay == 0) begin
                     in_ready_c = 1'b1;
                  end
               end else begin
                  idx_d = idx_q - IW'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (in_ready_c && bus.in_valid) begin
         vec_d = bus.in_data;
         idx_d = IDX_TOP;
         if (Delay > 0) begin
            state_d = S_WAIT;
            dly_d   = DLY_TOP;
         end else begin
            state_d = S_SEND;
         end
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.out_data  = out_data_c;
   assign bus.out_index = out_index_c;
   assign bus.out_last  = out_last_c;
   assign bus.out_done  = done_q;
endmodule

// File: tb/tb_serialising_pe.sv
// Scoreboard bench for serialising_pe: three instances cover Delay=0,
// Delay=3 and the single-element case.
module tb_serialising_pe;
   logic clk = 1'b0;
   logic res = 1'b1;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0] d;
      logic [3:0] i;
      logic       l;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];
   logic due0 = 1'b0;
   logic due1 = 1'b0;
   logic due2 = 1'b0;

   // e8..e0 as packed vectors, and the hand-derived emission order (e8 first).
   localparam logic [17:0] VEC_A = {2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
   localparam logic [17:0] VEC_B = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
   int ord_a[9] = '{3, 2, 1, 0, 3, 2, 1, 0, 3};
   int ord_b[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 1};

   serialising_pe_if #(.BitSize(2), .ImageSize(9)) b0 ();
   serialising_pe_if #(.BitSize(2), .ImageSize(9)) b1 ();
   serialising_pe_if #(.BitSize(4), .ImageSize(1)) b2 ();

   serialising_pe #(.BitSize(2), .ImageSize(9), .Delay(0)) u0 (.clk(clk), .res(res), .bus(b0));
   serialising_pe #(.BitSize(2), .ImageSize(9), .Delay(3)) u1 (.clk(clk), .res(res), .bus(b1));
   serialising_pe #(.BitSize(4), .ImageSize(1), .Delay(0)) u2 (.clk(clk), .res(res), .bus(b2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic push_vec(input int which, input bit use_b);
      exp_t e;
      for (int k = 0; k < 9; k++) begin
         e.d = 4'(use_b ? ord_b[k] : ord_a[k]);
         e.i = 4'(8 - k);
         e.l = (k == 8);
         if (which == 0) q0.push_back(e);
         else            q1.push_back(e);
      end
   endtask

   // Monitors: pop one expectation per accepted beat; out_done must follow a last beat.
   always @(negedge clk) begin : mon0
      exp_t e;
      logic nd;
      nd = 1'b0;
      if (b0.out_valid && b0.out_ready) begin
         if (q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL u0 beat: got index %0d required no beat", b0.out_index);
         end else begin
            e = q0.pop_front();
            chk("u0 data", 32'(b0.out_data), 32'(e.d));
            chk("u0 index", 32'(b0.out_index), 32'(e.i));
            chk("u0 last", 32'(b0.out_last), 32'(e.l));
            nd = e.l;
         end
      end
      if (due0 || b0.out_done) chk("u0 done", 32'(b0.out_done), 32'(due0));
      due0 = nd;
   end

   always @(negedge clk) begin : mon1
      exp_t e;
      logic nd;
      nd = 1'b0;
      if (b1.out_valid && b1.out_ready) begin
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL u1 beat: got index %0d required no beat", b1.out_index);
         end else begin
            e = q1.pop_front();
            chk("u1 data", 32'(b1.out_data), 32'(e.d));
            chk("u1 index", 32'(b1.out_index), 32'(e.i));
            chk("u1 last", 32'(b1.out_last), 32'(e.l));
            nd = e.l;
         end
      end
      if (due1 || b1.out_done) chk("u1 done", 32'(b1.out_done), 32'(due1));
      due1 = nd;
   end

   always @(negedge clk) begin : mon2
      exp_t e;
      logic nd;
      nd = 1'b0;
      if (b2.out_valid && b2.out_ready) begin
         if (q2.size() == 0) begin
            checks++; errors++;
            $display("FAIL u2 beat: got index %0d required no beat", b2.out_index);
         end else begin
            e = q2.pop_front();
            chk("u2 data", 32'(b2.out_data), 32'(e.d));
            chk("u2 index", 32'(b2.out_index), 32'(e.i));
            chk("u2 last", 32'(b2.out_last), 32'(e.l));
            nd = e.l;
         end
      end
      if (due2 || b2.out_done) chk("u2 done", 32'(b2.out_done), 32'(due2));
      due2 = nd;
   end

   // Runs u0 from the cycle after accept until out_done; optional 4-cycle stall at index 5.
   task automatic measure0(input string tag, input bit stall, input int exp_first, input int exp_done);
      int cycle = 1;
      int first = -1;
      int done = -1;
      int stalled = 0;
      while (done < 0 && cycle < 60) begin
         if (stall && stalled == 0 && b0.out_valid && b0.out_index == 4'd5) begin
            b0.out_ready = 1'b0;
            stalled = 1;
         end else if (stalled >= 1 && stalled <= 4) begin
            chk({tag, " stall valid"}, 32'(b0.out_valid), 1);
            chk({tag, " stall index"}, 32'(b0.out_index), 5);
            chk({tag, " stall data"}, 32'(b0.out_data), 3);
            if (stalled == 4) b0.out_ready = 1'b1;
            stalled++;
         end
         if (b0.out_valid && first < 0) first = cycle;
         if (b0.out_done) done = cycle;
         if (done < 0) begin
            @(posedge clk); #1;
            cycle++;
         end
      end
      b0.out_ready = 1'b1;
      chk({tag, " first valid cycle"}, first, exp_first);
      chk({tag, " done cycle"}, done, exp_done);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "bench timed out");
   end

   initial begin : stim
      int cycle, first, done, bad, nvalid, ndone, found;
      bit pend, take;

      b0.in_valid = 1'b0; b0.in_data = '0; b0.out_ready = 1'b1;
      b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b1;
      b2.in_valid = 1'b0; b2.in_data = '0; b2.out_ready = 1'b1;

      // Reset state.
      #12;
      chk("rst in_ready", 32'(b0.in_ready), 1);
      chk("rst out_valid", 32'(b0.out_valid), 0);
      chk("rst out_data", 32'(b0.out_data), 0);
      chk("rst out_index", 32'(b0.out_index), 0);
      chk("rst out_last", 32'(b0.out_last), 0);
      chk("rst out_done", 32'(b0.out_done), 0);
      @(posedge clk); #1;
      res = 1'b0;

      // 1: Delay=0 single vector; in_data changes after accept must not matter.
      @(posedge clk); #1;
      chk("t1 in_ready", 32'(b0.in_ready), 1);
      b0.in_data = VEC_A; b0.in_valid = 1'b1; push_vec(0, 0);
      @(posedge clk); #1;
      b0.in_valid = 1'b0; b0.in_data = VEC_B;
      measure0("t1", 0, 1, 10);

      // 2: Delay=3; in_ready low from accept until back in IDLE.
      @(posedge clk); #1;
      b1.in_data = VEC_A; b1.in_valid = 1'b1; push_vec(1, 0);
      @(posedge clk); #1;
      b1.in_valid = 1'b0;
      cycle = 1; first = -1; done = -1; bad = 0;
      while (done < 0 && cycle < 60) begin
         if (b1.out_valid && first < 0) first = cycle;
         if (b1.out_done) done = cycle;
         else if (b1.in_ready) bad++;
         if (done < 0) begin
            @(posedge clk); #1;
            cycle++;
         end
      end
      chk("t2 first valid cycle", first, 4);
      chk("t2 done cycle", done, 13);
      chk("t2 in_ready low cycles", bad, 0);
      chk("t2 in_ready back", 32'(b1.in_ready), 1);

      // 3: backpressure at index 5 for 4 cycles.
      @(posedge clk); #1;
      b0.in_data = VEC_B; b0.in_valid = 1'b1; push_vec(0, 1);
      @(posedge clk); #1;
      b0.in_valid = 1'b0;
      measure0("t3", 1, 1, 14);

      // 4: back-to-back A then B with in_valid held high.
      @(posedge clk); #1;
      b0.in_data = VEC_A; b0.in_valid = 1'b1; push_vec(0, 0);
      @(posedge clk); #1;
      b0.in_data = VEC_B; push_vec(0, 1);
      pend = 1'b1; nvalid = 0; ndone = 0;
      for (int c = 1; c <= 20; c++) begin
         if (c <= 18 && b0.out_valid) nvalid++;
         if (b0.out_done) ndone++;
         take = pend && b0.in_ready;
         @(posedge clk); #1;
         if (take) begin
            b0.in_valid = 1'b0;
            pend = 1'b0;
         end
      end
      chk("t4 contiguous beats", nvalid, 18);
      chk("t4 done pulses", ndone, 2);
      chk("t4 second vector taken", 32'(pend), 0);

      // 5: asynchronous reset at index 4, then a clean vector.
      b0.in_data = VEC_A; b0.in_valid = 1'b1; push_vec(0, 0);
      @(posedge clk); #1;
      b0.in_valid = 1'b0;
      found = 0;
      for (int c = 0; c < 30 && found == 0; c++) begin
         if (b0.out_valid && b0.out_index == 4'd4) found = 1;
         else begin
            @(posedge clk); #1;
         end
      end
      chk("t5 reached index 4", found, 1);
      #2 res = 1'b1;
      #1;
      chk("t5 abort out_valid", 32'(b0.out_valid), 0);
      chk("t5 abort out_data", 32'(b0.out_data), 0);
      chk("t5 abort out_done", 32'(b0.out_done), 0);
      chk("t5 abort in_ready", 32'(b0.in_ready), 1);
      q0.delete();
      @(posedge clk); @(posedge clk); #1;
      res = 1'b0;
      chk("t5 after reset out_done", 32'(b0.out_done), 0);
      b0.in_data = VEC_A; b0.in_valid = 1'b1; push_vec(0, 0);
      @(posedge clk); #1;
      b0.in_valid = 1'b0;
      measure0("t5", 0, 1, 10);

      // 6: ImageSize=1, BitSize=4.
      @(posedge clk); #1;
      begin
         exp_t e;
         e.d = 4'hA; e.i = 4'd0; e.l = 1'b1;
         q2.push_back(e);
      end
      b2.in_data = 4'hA; b2.in_valid = 1'b1;
      @(posedge clk); #1;
      b2.in_valid = 1'b0;
      cycle = 1; first = -1; done = -1;
      while (done < 0 && cycle < 20) begin
         if (b2.out_valid && first < 0) first = cycle;
         if (b2.out_done) done = cycle;
         if (done < 0) begin
            @(posedge clk); #1;
            cycle++;
         end
      end
      chk("t6 first valid cycle", first, 1);
      chk("t6 done cycle", done, 2);

      repeat (3) @(posedge clk);
      #1;
      chk("u0 leftover expected beats", q0.size(), 0);
      chk("u1 leftover expected beats", q1.size(), 0);
      chk("u2 leftover expected beats", q2.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
